// File: rtl/i2c_reg_init_seq_if.sv
// Byte-write handshake between the register-init sequencer and an I2C byte-write master.
interface i2c_reg_init_seq_if;
    logic       wr_req;
    logic [6:0] wr_dev;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       wr_nack;

    modport master (
        output wr_req,
        output wr_dev,
        output wr_reg,
        output wr_data,
        input  wr_done,
        input  wr_nack
    );

    modport slave (
        input  wr_req,
        input  wr_dev,
        input  wr_reg,
        input  wr_data,
        output wr_done,
        output wr_nack
    );
endinterface

// File: rtl/i2c_reg_init_seq.sv
// Power-up register-initialisation sequencer: waits a power-up delay, then writes a table
// of register/data pairs over an I2C byte-write master with NACK/timeout retry.
module i2c_reg_init_seq #(
    parameter int         PWRUP_DLY = 60000,
    parameter int         N_REGS    = 8,
    parameter logic [6:0] DEV_ADDR  = 7'h57,
    parameter int         RETRY_MAX = 3,
    parameter int         TIMEOUT   = 50000,
    parameter int         GAP       = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [N_REGS*16-1:0]  cfg_table,
    input  logic                  reinit,
    i2c_reg_init_seq_if.master    bus,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_err,
    output logic [7:0]            err_idx,
    output logic [2:0]            state_cnt,
    output logic [7:0]            idx
);

    localparam int DLY_W = (PWRUP_DLY > 1) ? $clog2(PWRUP_DLY + 1) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int RTY_W = $clog2(RETRY_MAX + 2);

    typedef enum logic [2:0] {
        S_DLY   = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_r;
    logic [DLY_W-1:0]   dly_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [RTY_W-1:0]   retry_r;
    logic [7:0]         idx_r;
    logic [7:0]         err_idx_r;
    logic               wr_req_r;
    logic [6:0]         wr_dev_r;
    logic [7:0]         wr_reg_r;
    logic [7:0]         wr_data_r;
    logic               busy_r;
    logic               init_done_r;
    logic               init_err_r;
    logic [15:0]        entry_s;
    logic               last_s;

    // Table entry selected by the current index (one-hot AND-OR mux, no wide shifter).
    always_comb begin
        entry_s = 16'h0000;
        for (int i = 0; i < N_REGS; i++) begin
            entry_s = entry_s | ({16{idx_r == 8'(i)}} & cfg_table[16*i +: 16]);
        end
    end

    assign last_s = (idx_r == 8'(N_REGS - 1));

    // Sequencer FSM; all outputs are registered here.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= S_DLY;
            dly_cnt_r   <= '0;
            to_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            retry_r     <= '0;
            idx_r       <= 8'd0;
            err_idx_r   <= 8'd0;
            wr_req_r    <= 1'b0;
            wr_dev_r    <= DEV_ADDR;
            wr_reg_r    <= 8'd0;
            wr_data_r   <= 8'd0;
            busy_r      <= 1'b1;
            init_done_r <= 1'b0;
            init_err_r  <= 1'b0;
        end else begin
            wr_req_r <= 1'b0;
            case (state_r)
                S_DLY: begin
                    if (dly_cnt_r == DLY_W'(PWRUP_DLY - 1)) begin
                        dly_cnt_r <= '0;
                        state_r   <= S_ISSUE;
                    end else begin
                        dly_cnt_r <= dly_cnt_r + 1'b1;
                    end
                end
                S_ISSUE: begin
                    wr_dev_r  <= DEV_ADDR;
                    wr_reg_r  <= entry_s[15:8];
                    wr_data_r <= entry_s[7:0];
                    wr_req_r  <= 1'b1;
                    to_cnt_r  <= '0;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    // wr_done wins over a coincident timeout expiry
                    if (bus.wr_done && !bus.wr_nack) begin
                        retry_r <= '0;
                        if (GAP == 0) begin
                            if (last_s) begin
                                init_done_r <= 1'b1;
                                busy_r      <= 1'b0;
                                state_r     <= S_DONE;
                            end else begin
                                idx_r   <= idx_r + 8'd1;
                                state_r <= S_ISSUE;
                            end
                        end else begin
                            gap_cnt_r <= '0;
                            state_r   <= S_GAP;
                        end
                    end else if (bus.wr_done || (to_cnt_r == TO_W'(TIMEOUT - 1))) begin
                        if (retry_r < RTY_W'(RETRY_MAX)) begin
                            retry_r <= retry_r + 1'b1;
                            state_r <= S_ISSUE;
                        end else begin
                            err_idx_r  <= idx_r;
                            init_err_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= S_ERR;
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP - 1)) begin
                        gap_cnt_r <= '0;
                        if (last_s) begin
                            init_done_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= S_DONE;
                        end else begin
                            idx_r   <= idx_r + 8'd1;
                            state_r <= S_ISSUE;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (reinit) begin
                        init_done_r <= 1'b0;
                        init_err_r  <= 1'b0;
                        idx_r       <= 8'd0;
                        retry_r     <= '0;
                        dly_cnt_r   <= '0;
                        busy_r      <= 1'b1;
                        state_r     <= S_DLY;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    dly_cnt_r   <= '0;
                    retry_r     <= '0;
                    idx_r       <= 8'd0;
                    init_done_r <= 1'b0;
                    init_err_r  <= 1'b0;
                    busy_r      <= 1'b1;
                    state_r     <= S_DLY;
                end
            endcase
        end
    end

    assign bus.wr_req  = wr_req_r;
    assign bus.wr_dev  = wr_dev_r;
    assign bus.wr_reg  = wr_reg_r;
    assign bus.wr_data = wr_data_r;
    assign busy        = busy_r;
    assign init_done   = init_done_r;
    assign init_err    = init_err_r;
    assign err_idx     = err_idx_r;
    assign state_cnt   = state_r;
    assign idx         = idx_r;

endmodule

// File: doc/i2c_reg_init_seq.md
Name: i2c_reg_init_seq

Overview:
- Parametrised power-up register-initialisation sequencer for I2C sensors such as the MAX30102.
- Waits a configurable power-up delay, then walks a table of N register/data pairs.
- Issues one byte-write per entry through an external I2C byte-write master using a req/done handshake.
- Adds NACK/timeout retry, inter-write gap, software re-init and done/error status; replaces the fixed single-pulse init-enable scheme.

Parameters:
- PWRUP_DLY, 60000, cycles from reset release to the first write
- N_REGS, 8, table entries (1..255)
- DEV_ADDR, 7'h57, 7-bit I2C device address
- RETRY_MAX, 3, extra attempts per entry after the first failure
- TIMEOUT, 50000, max cycles waiting for wr_done before the attempt counts as failed
- GAP, 16, idle cycles after each successful write before the next entry

Ports:
- Clk, input, 1, system clock
- Rst_n, input, 1, reset
- cfg_table, input, N_REGS*16, entry i = bits [16i+15:16i]: {reg[15:8], data[7:0]}; entry 0 is written first
- reinit, input, 1, single-cycle request to rerun the full sequence
- wr_req, output, 1, one-cycle write request to the I2C master
- wr_dev, output, 7, device address (constant DEV_ADDR)
- wr_reg, output, 8, register address of the current entry
- wr_data, output, 8, data byte of the current entry
- wr_done, input, 1, one-cycle completion pulse from the master
- wr_nack, input, 1, qualified by wr_done; 1 = slave NACK
- busy, output, 1, high in every state except DONE and ERR
- init_done, output, 1, level; sequence completed with no error
- init_err, output, 1, level; an entry exhausted its retries
- err_idx, output, 8, index of the failing entry (valid while init_err)
- state_cnt, output, 3, state encoding for debug
- idx, output, 8, current table index

Behaviour:
- Reset: Rst_n is asynchronous and active-low; clock is Clk.
  - State goes to DLY; all counters clear.
  - Reset values: wr_req=0, wr_reg=0, wr_data=0, idx=0, init_done=0, init_err=0, err_idx=0, busy=1.
- States and state_cnt codes: DLY=0, ISSUE=1, WAIT=2, GAP=3, DONE=4, ERR=5.
- DLY:
  - Counter increments each cycle.
  - When the counter reaches PWRUP_DLY-1, go to ISSUE. The first wr_req therefore rises in cycle PWRUP_DLY+1 after reset release.
- ISSUE:
  - Drive wr_reg/wr_data from entry idx.
  - Assert wr_req for exactly one cycle, clear the timeout counter, go to WAIT.
- Field stability: wr_reg, wr_data and wr_dev are registered and hold constant from ISSUE until the next ISSUE.
- WAIT:
  - wr_done with wr_nack=0: clear the retry counter, go to GAP.
  - wr_done with wr_nack=1, or timeout counter reaching TIMEOUT-1: failure.
    - If retry counter < RETRY_MAX: increment it and go to ISSUE, same idx.
    - Otherwise latch err_idx=idx, set init_err, go to ERR.
  - wr_done in the same cycle as the timeout expiry: wr_done takes priority.
- GAP:
  - Wait GAP cycles (GAP=0 skips this state).
  - Then, if idx==N_REGS-1, set init_done and go to DONE; otherwise idx+1 and go to ISSUE.
- DONE / ERR:
  - Outputs hold.
  - reinit: clear init_done, init_err, idx, retry counter and delay counter; go to DLY (full power-up delay repeats).
- Ignored events:
  - reinit in any other state is ignored (no queueing).
  - wr_done outside WAIT is ignored.
- Retry bound: total attempts per entry are at most RETRY_MAX+1.
- Mutual exclusion: init_done and init_err are never both 1.
- Asynchronous reset mid-transfer simply aborts; the master's reset is the owner's responsibility.

Test Plan (PWRUP_DLY=10, N_REGS=3, RETRY_MAX=2, TIMEOUT=20, GAP=2, table {0x09,0x40},{0x0A,0x27},{0x0C,0x24}):
- Reset release, master always acks after 5 cycles:
  - First wr_req in cycle 11 with wr_dev=0x57, reg 0x09, data 0x40.
  - Three writes occur in table order.
  - init_done=1, busy=0, state_cnt=4, idx=2.
- NACK on the first two attempts of entry 1, ack on the third:
  - Exactly 3 wr_req pulses carry reg 0x0A.
  - Sequence completes with init_done=1, init_err=0.
- Entry 2 always NACKs:
  - 3 attempts on reg 0x0C, then init_err=1, err_idx=2, state_cnt=5, no further wr_req.
- Master never returns wr_done:
  - Retry fires 20 cycles after each wr_req.
  - After 3 attempts: init_err=1, err_idx=0.
- reinit pulsed in WAIT: ignored and the sequence finishes normally. reinit pulsed in DONE:
  - init_done drops next cycle.
  - First new wr_req arrives 11 cycles later with entry 0.
- Rst_n asserted while in WAIT on entry 1:
  - All outputs return to reset values immediately.
  - After release the sequence restarts from entry 0 after the full delay.
